// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings plus the response-FSM state type used by the
// block-RAM controller.
package ahb_pkg;

  // HTRANS transfer types
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HSIZE codes the controller understands; anything wider is rejected
  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // HRESP values
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Response FSM: OKAY for normal traffic, ERR1/ERR2 form the two-cycle
  // AHB error response
  typedef enum logic [1:0] {
    ST_OKAY = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } resp_state_e;

endpackage : ahb_pkg

// File: rtl/ahb_byte_lane_dec.sv
// Decodes HSIZE and the low address bits into a 4-bit byte-lane mask and
// flags transfers the controller cannot serve (misaligned halfword or a
// size wider than one word).
module ahb_byte_lane_dec
  import ahb_pkg::*;
(
  input  logic [2:0] hsize_i,
  input  logic [1:0] addr_lo_i,
  output logic [3:0] mask_o,
  output logic       illegal_o
);

  // Lane mask and legality are pure functions of size and byte offset
  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves it unassigned and infers a latch.
    mask_o    = 4'b0000;
    illegal_o = 1'b0;
    unique case (hsize_i)
      HSIZE_BYTE: mask_o = 4'b0001 << addr_lo_i;
      HSIZE_HALF: begin
        if (addr_lo_i[0]) begin
          illegal_o = 1'b1;
        end else begin
          mask_o = 4'b0011 << addr_lo_i;
        end
      end
      HSIZE_WORD: mask_o = 4'b1111;
      default:    illegal_o = 1'b1;
    endcase
  end

endmodule : ahb_byte_lane_dec

// File: rtl/ahb_ram_ctrl.sv
// AHB-Lite slave in front of a simple dual-port block RAM with a registered
// read port. Reads are issued straight from the address phase so data comes
// back with zero wait states; a one-entry write buffer covers the case where
// the RAM has not yet absorbed the immediately preceding write.
module ahb_ram_ctrl
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  // AHB-Lite slave
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  // Block RAM
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [31:0]           dina,
  output logic [3:0]            wea,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic [31:0]           doutb
);

  // Address-phase decode
  logic                  xfer_valid;
  logic                  xfer_accept;
  logic [ADDR_WIDTH-1:0] xfer_word_addr;
  logic [3:0]            lane_mask;
  logic                  lane_illegal;

  // Data-phase registers
  logic                  dp_valid_q, dp_valid_d;
  logic                  dp_write_q, dp_write_d;
  logic [ADDR_WIDTH-1:0] dp_addr_q,  dp_addr_d;
  logic [3:0]            dp_mask_q,  dp_mask_d;

  // Read-after-write buffer
  logic                  buf_valid_q, buf_valid_d;
  logic [ADDR_WIDTH-1:0] buf_addr_q,  buf_addr_d;
  logic [31:0]           buf_data_q,  buf_data_d;
  logic [3:0]            buf_mask_q,  buf_mask_d;

  // Response FSM with registered bus outputs
  resp_state_e           state_q;
  logic                  hreadyout_q;
  logic                  hresp_q;

  logic                  wr_active;
  logic                  rd_active;
  logic                  wr_done;
  logic                  buf_hit_wr;
  logic                  buf_hit_rd;

  // Upper address bits alias onto the RAM, and HTRANS[0] only separates
  // SEQ from NONSEQ which the RAM does not care about.
  logic                  unused_bits;
  assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  assign xfer_word_addr = HADDR[ADDR_WIDTH+1:2];
  assign xfer_valid     = HSEL & HTRANS[1] & HREADY;
  // The first error cycle holds HREADY low, so nothing is sampled there
  assign xfer_accept    = xfer_valid & (state_q != ST_ERR1);

  ahb_byte_lane_dec u_lane_dec (
    .hsize_i   (HSIZE),
    .addr_lo_i (HADDR[1:0]),
    .mask_o    (lane_mask),
    .illegal_o (lane_illegal)
  );

  // Capture the next data phase whenever the bus advances
  always_comb begin
    dp_valid_d = dp_valid_q;
    dp_write_d = dp_write_q;
    dp_addr_d  = dp_addr_q;
    dp_mask_d  = dp_mask_q;
    if (HREADY) begin
      dp_valid_d = xfer_accept & ~lane_illegal;
      dp_write_d = HWRITE;
      dp_addr_d  = xfer_word_addr;
      dp_mask_d  = lane_mask;
    end
  end

  // Data-phase state; async clear also kills an in-flight write strobe
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      // NOTE: sequential state is assigned with <= so every register samples the pre-edge values of its neighbours.
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= '0;
      dp_mask_q  <= 4'b0000;
    end else begin
      dp_valid_q <= dp_valid_d;
      dp_write_q <= dp_write_d;
      dp_addr_q  <= dp_addr_d;
      dp_mask_q  <= dp_mask_d;
    end
  end

  assign wr_active = dp_valid_q &  dp_write_q;
  assign rd_active = dp_valid_q & ~dp_write_q;
  assign wr_done   = wr_active & HREADY;

  // RAM write port: the strobe lives only for the write data phase
  assign addra = dp_addr_q;
  assign dina  = HWDATA;
  assign wea   = wr_active ? dp_mask_q : 4'b0000;

  // RAM read port follows the bus address every cycle
  assign addrb = xfer_word_addr;

  assign buf_hit_wr = buf_valid_q & (buf_addr_q == dp_addr_q);
  assign buf_hit_rd = buf_valid_q & (buf_addr_q == dp_addr_q);

  // Buffer next state: merge into a matching entry, otherwise replace it
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    buf_mask_d  = buf_mask_q;
    if (wr_done) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = dp_addr_q;
      buf_mask_d  = (buf_hit_wr ? buf_mask_q : 4'b0000) | dp_mask_q;
      for (int i = 0; i < 4; i++) begin
        if (dp_mask_q[i]) begin
          buf_data_d[8*i +: 8] = HWDATA[8*i +: 8];
        end
      end
    end
  end

  // Buffer valid flag is the only part that needs a reset
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      buf_valid_q <= 1'b0;
    end else begin
      buf_valid_q <= buf_valid_d;
    end
  end

  // Buffer payload, qualified everywhere by buf_valid_q
  always_ff @(posedge HCLK) begin
    // NOTE: storage-like payload is left out of reset; its valid flag already guards every use.
    buf_addr_q <= buf_addr_d;
    buf_data_q <= buf_data_d;
    buf_mask_q <= buf_mask_d;
  end

  // Read data: buffered lanes override the RAM, zero outside read phases
  always_comb begin
    HRDATA = 32'h0000_0000;
    if (rd_active) begin
      for (int i = 0; i < 4; i++) begin
        HRDATA[8*i +: 8] = (buf_hit_rd && buf_mask_q[i]) ? buf_data_q[8*i +: 8]
                                                         : doutb[8*i +: 8];
      end
    end
  end

  // Response FSM: two-cycle ERROR for illegal transfers, OKAY otherwise
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= ST_OKAY;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
    end else begin
      unique case (state_q)
        ST_OKAY, ST_ERR2: begin
          if (xfer_accept && lane_illegal) begin
            state_q     <= ST_ERR1;
            hreadyout_q <= 1'b0;
            hresp_q     <= HRESP_ERROR;
          end else begin
            state_q     <= ST_OKAY;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
          end
        end
        ST_ERR1: begin
          state_q     <= ST_ERR2;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_ERROR;
        end
        default: begin
          state_q     <= ST_OKAY;
          hreadyout_q <= 1'b1;
          hresp_q     <= HRESP_OKAY;
        end
      endcase
    end
  end

  assign HREADYOUT = hreadyout_q;
  assign HRESP     = hresp_q;

endmodule : ahb_ram_ctrl
